// File: rtl/mux_rr_nx1_pkg.sv
// mux_rr_nx1_pkg -- constants and helpers shared by the mux_rr_nx1 block.
//   MUX_MODE_SEL : MODE value for direct selection via SEL
//   MUX_MODE_RR  : MODE value for round-robin arbitration over IN_VALID
//   rr_next()    : round-robin pointer successor of a granted index
package mux_rr_nx1_pkg;

    localparam logic MUX_MODE_SEL = 1'b0;
    localparam logic MUX_MODE_RR  = 1'b1;

    // Pointer moves to one past the winner so the winner has lowest priority next time.
    function automatic int rr_next(input int gnt, input int n);
        return (gnt == n - 1) ? 0 : gnt + 1;
    endfunction

endpackage

// File: rtl/mux_rr_nx1_if.sv
// mux_rr_nx1_if -- producer/consumer bundle of the N:1 word selector.
//   MODE, SEL          : selection control
//   IN_DATA, IN_VALID  : flattened producer words and requests
//   IN_READY           : per-producer accept (one-hot or zero)
//   Y, Y_VALID, Y_SRC  : registered output word, valid flag, source index
//   Y_READY            : consumer accept
// master = environment side, slave = selector side.
interface mux_rr_nx1_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = 3
);
    logic                 MODE;
    logic [SEL_W-1:0]     SEL;
    logic [N*WIDTH-1:0]   IN_DATA;
    logic [N-1:0]         IN_VALID;
    logic [N-1:0]         IN_READY;
    logic [WIDTH-1:0]     Y;
    logic                 Y_VALID;
    logic                 Y_READY;
    logic [SEL_W-1:0]     Y_SRC;

    modport master (
        output MODE, SEL, IN_DATA, IN_VALID, Y_READY,
        input  IN_READY, Y, Y_VALID, Y_SRC
    );

    modport slave (
        input  MODE, SEL, IN_DATA, IN_VALID, Y_READY,
        output IN_READY, Y, Y_VALID, Y_SRC
    );
endinterface

// File: rtl/mux_rr_nx1_rr_pick.sv
// rr_pick -- combinational rotate-priority finder.
//   REQ       : request vector
//   PTR       : highest-priority index (must be < N)
//   GNT       : first requesting index at or above PTR, wrapping to 0
//   GNT_VALID : any request present
module rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     REQ,
    input  logic [SEL_W-1:0] PTR,
    output logic [SEL_W-1:0] GNT,
    output logic             GNT_VALID
);
    logic [SEL_W-1:0] hi_gnt, lo_gnt;
    logic             hi_vld, lo_vld;

    // Two searches instead of a rotate: lowest request at/above PTR, and
    // lowest request overall (the wrapped case). Scanning downward leaves
    // the lowest index as the final assignment.
    always_comb begin
        hi_gnt = '0;
        lo_gnt = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                lo_gnt = SEL_W'(i);
                lo_vld = 1'b1;
                if (i >= int'(PTR)) begin
                    hi_gnt = SEL_W'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        GNT       = hi_vld ? hi_gnt : lo_gnt;
        GNT_VALID = lo_vld;
    end
endmodule

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1 -- registered N:1 word selector with valid/ready handshake.
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset
//   bus   : mux_rr_nx1_if.slave (select control, producer and consumer sides)
// MODE=0 grants SEL if it requests; MODE=1 grants round-robin from ptr.
// The output slot reloads whenever it is empty or being drained.
module mux_rr_nx1
    import mux_rr_nx1_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    mux_rr_nx1_if.slave   bus
);
    localparam int OFF_W = $clog2(N * WIDTH);

    logic [WIDTH-1:0]        y_q, y_d;
    logic [SEL_W-1:0]        src_q, src_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic                    vld_q, vld_d;

    logic [SEL_W-1:0]        rr_gnt, gnt;
    logic                    rr_vld, gnt_vld;
    logic [(1<<SEL_W)-1:0]   vld_ext;
    logic                    load, xfer;
    logic [OFF_W-1:0]        off;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .REQ       (bus.IN_VALID),
        .PTR       (ptr_q),
        .GNT       (rr_gnt),
        .GNT_VALID (rr_vld)
    );

    // Zero-padding the request vector to 2**SEL_W makes SEL >= N read a
    // zero request, so out-of-range selects never grant.
    always_comb begin
        vld_ext        = '0;
        vld_ext[N-1:0] = bus.IN_VALID;
        if (bus.MODE == MUX_MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end else begin
            gnt     = bus.SEL;
            gnt_vld = vld_ext[bus.SEL];
        end
    end

    assign load = !vld_q || bus.Y_READY;
    // Held off during reset so no producer sees an accept that gets dropped.
    assign xfer = RST_N && load && gnt_vld;
    assign off  = OFF_W'(gnt) * OFF_W'(WIDTH);

    always_comb begin
        bus.IN_READY = '0;
        for (int i = 0; i < N; i++) begin
            bus.IN_READY[i] = xfer && (gnt == SEL_W'(i));
        end
    end

    always_comb begin
        y_d   = y_q;
        src_d = src_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (load) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                y_d   = bus.IN_DATA[off +: WIDTH];
                src_d = gnt;
                if (bus.MODE == MUX_MODE_RR) begin
                    ptr_d = SEL_W'(rr_next(int'(gnt), N));
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            y_q   <= '0;
            src_q <= '0;
            vld_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            src_q <= src_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    assign bus.Y       = y_q;
    assign bus.Y_SRC   = src_q;
    assign bus.Y_VALID = vld_q;
endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1 -- self-checking bench for mux_rr_nx1.
// dut_a: 8 x 32-bit inputs; dut_b: 5 x 8-bit inputs (non-power-of-two N).
module tb_mux_rr_nx1;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    mux_rr_nx1_if #(.WIDTH(32), .N(8), .SEL_W(3)) bus_a ();
    mux_rr_nx1_if #(.WIDTH(8),  .N(5), .SEL_W(3)) bus_b ();

    mux_rr_nx1 #(.WIDTH(32), .N(8), .SEL_W(3)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
    mux_rr_nx1 #(.WIDTH(8),  .N(5), .SEL_W(3)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

    typedef struct {
        logic [31:0] d;
        logic [2:0]  src;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < 8; i++) bus_a.IN_DATA[i*32 +: 32] = pat(i);
        for (int i = 0; i < 5; i++) bus_b.IN_DATA[i*8 +: 8] = 8'hA0 + 8'(i);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus_a.MODE = 1'b1; bus_a.SEL = 3'd0; bus_a.IN_VALID = 8'hFF; bus_a.Y_READY = 1'b1;
        repeat (2) begin
            tick();
            n_cmp++; if (bus_a.Y !== 32'h0) begin n_bad++; $display("FAIL reset_y: got %h want 0", bus_a.Y); end
            n_cmp++; if (bus_a.Y_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_yvalid: got %b want 0", bus_a.Y_VALID); end
            n_cmp++; if (bus_a.Y_SRC !== 3'd0) begin n_bad++; $display("FAIL reset_ysrc: got %0d want 0", bus_a.Y_SRC); end
            n_cmp++; if (bus_a.IN_READY !== 8'h00) begin n_bad++; $display("FAIL reset_inready: got %h want 00", bus_a.IN_READY); end
        end
        RST_N = 1'b1;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h01) begin n_bad++; $display("FAIL reset_first_grant: got %h want 01", bus_a.IN_READY); end
        tick();
        n_cmp++; if (bus_a.Y_VALID !== 1'b1 || bus_a.Y_SRC !== 3'd0 || bus_a.Y !== pat(0)) begin
            n_bad++; $display("FAIL reset_first_word: got v=%b src=%0d y=%h want v=1 src=0 y=%h",
                              bus_a.Y_VALID, bus_a.Y_SRC, bus_a.Y, pat(0));
        end
    endtask

    task automatic test_direct();
        do_reset();
        bus_a.MODE = 1'b0; bus_a.SEL = 3'd5; bus_a.IN_VALID = 8'hFF; bus_a.Y_READY = 1'b1;
        bus_a.IN_DATA[5*32 +: 32] = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h20) begin n_bad++; $display("FAIL direct_inready: got %h want 20", bus_a.IN_READY); end
        tick();
        n_cmp++; if (bus_a.Y !== 32'hDEADBEEF || bus_a.Y_SRC !== 3'd5 || bus_a.Y_VALID !== 1'b1) begin
            n_bad++; $display("FAIL direct_word: got y=%h src=%0d v=%b want y=deadbeef src=5 v=1",
                              bus_a.Y, bus_a.Y_SRC, bus_a.Y_VALID);
        end
        bus_a.IN_VALID = 8'hDF;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h00) begin n_bad++; $display("FAIL direct_noreq_inready: got %h want 00", bus_a.IN_READY); end
        tick();
        n_cmp++; if (bus_a.Y_VALID !== 1'b0) begin n_bad++; $display("FAIL direct_bubble: got v=%b want 0", bus_a.Y_VALID); end
        n_cmp++; if (bus_a.Y !== 32'hDEADBEEF || bus_a.Y_SRC !== 3'd5) begin
            n_bad++; $display("FAIL direct_hold: got y=%h src=%0d want y=deadbeef src=5", bus_a.Y, bus_a.Y_SRC);
        end
        // Direct transfers must not have moved the round-robin pointer.
        bus_a.IN_DATA[5*32 +: 32] = pat(5);
        bus_a.MODE = 1'b1; bus_a.IN_VALID = 8'hFF;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h01) begin n_bad++; $display("FAIL direct_ptr_kept: got %h want 01", bus_a.IN_READY); end
        tick();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   x;
        do_reset();
        bus_a.MODE = 1'b1; bus_a.IN_VALID = 8'hFF; bus_a.Y_READY = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            x = k % 8;
            sbq.push_back('{d: pat(x), src: 3'(x)});
            n_cmp++; if (bus_a.IN_READY !== 8'(1 << x)) begin n_bad++; $display("FAIL rr_inready[%0d]: got %h want %h", k, bus_a.IN_READY, 8'(1 << x)); end
            tick();
            e = sbq.pop_front();
            n_cmp++; if (bus_a.Y_VALID !== 1'b1 || bus_a.Y_SRC !== e.src || bus_a.Y !== e.d) begin
                n_bad++; $display("FAIL rr_word[%0d]: got v=%b src=%0d y=%h want v=1 src=%0d y=%h",
                                  k, bus_a.Y_VALID, bus_a.Y_SRC, bus_a.Y, e.src, e.d);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        exp_t e;
        int   seq [4] = '{7, 1, 7, 1};
        do_reset();
        bus_a.MODE = 1'b1; bus_a.IN_VALID = 8'hFF; bus_a.Y_READY = 1'b1;
        repeat (2) tick();           // grants 0 and 1 leave ptr at 2
        bus_a.IN_VALID = 8'b1000_0010;
        #1;
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{d: pat(seq[k]), src: 3'(seq[k])});
            n_cmp++; if (bus_a.IN_READY !== 8'(1 << seq[k])) begin n_bad++; $display("FAIL sparse_inready[%0d]: got %h want %h", k, bus_a.IN_READY, 8'(1 << seq[k])); end
            tick();
            e = sbq.pop_front();
            n_cmp++; if (bus_a.Y_VALID !== 1'b1 || bus_a.Y_SRC !== e.src || bus_a.Y !== e.d) begin
                n_bad++; $display("FAIL sparse_word[%0d]: got v=%b src=%0d y=%h want v=1 src=%0d y=%h",
                                  k, bus_a.Y_VALID, bus_a.Y_SRC, bus_a.Y, e.src, e.d);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        bus_a.MODE = 1'b1; bus_a.IN_VALID = 8'hFF; bus_a.Y_READY = 1'b1;
        tick();                      // word 0 in Y, ptr = 1
        bus_a.Y_READY = 1'b0;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h00) begin n_bad++; $display("FAIL bp_inready_initial: got %h want 00", bus_a.IN_READY); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus_a.Y_VALID !== 1'b1 || bus_a.Y_SRC !== 3'd0 || bus_a.Y !== pat(0)) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b src=%0d y=%h want v=1 src=0 y=%h",
                                  k, bus_a.Y_VALID, bus_a.Y_SRC, bus_a.Y, pat(0));
            end
            n_cmp++; if (bus_a.IN_READY !== 8'h00) begin n_bad++; $display("FAIL bp_inready[%0d]: got %h want 00", k, bus_a.IN_READY); end
        end
        bus_a.Y_READY = 1'b1;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h02) begin n_bad++; $display("FAIL bp_resume_inready: got %h want 02", bus_a.IN_READY); end
        tick();
        n_cmp++; if (bus_a.Y_SRC !== 3'd1 || bus_a.Y !== pat(1)) begin
            n_bad++; $display("FAIL bp_resume_word: got src=%0d y=%h want src=1 y=%h", bus_a.Y_SRC, bus_a.Y, pat(1));
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        bus_a.MODE = 1'b1; bus_a.IN_VALID = 8'hFF; bus_a.Y_READY = 1'b1;
        repeat (3) tick();           // grants 0,1,2 leave ptr at 3
        bus_a.MODE = 1'b0; bus_a.SEL = 3'd6;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h40) begin n_bad++; $display("FAIL mode_sel_inready: got %h want 40", bus_a.IN_READY); end
        tick();
        n_cmp++; if (bus_a.Y_SRC !== 3'd6 || bus_a.Y !== pat(6)) begin
            n_bad++; $display("FAIL mode_sel_word: got src=%0d y=%h want src=6 y=%h", bus_a.Y_SRC, bus_a.Y, pat(6));
        end
        bus_a.MODE = 1'b1;
        #1;
        n_cmp++; if (bus_a.IN_READY !== 8'h08) begin n_bad++; $display("FAIL mode_rr_resume: got %h want 08", bus_a.IN_READY); end
        tick();
        n_cmp++; if (bus_a.Y_SRC !== 3'd3) begin n_bad++; $display("FAIL mode_rr_word: got src=%0d want 3", bus_a.Y_SRC); end
        bus_a.IN_VALID = 8'h00;
    endtask

    task automatic test_non_pow2();
        exp_t e;
        int   x;
        bus_a.IN_VALID = 8'h00;
        do_reset();
        bus_b.MODE = 1'b0; bus_b.SEL = 3'd6; bus_b.IN_VALID = 5'h1F; bus_b.Y_READY = 1'b1;
        #1;
        n_cmp++; if (bus_b.IN_READY !== 5'h00) begin n_bad++; $display("FAIL np2_sel6_inready: got %h want 00", bus_b.IN_READY); end
        tick();
        n_cmp++; if (bus_b.Y_VALID !== 1'b0) begin n_bad++; $display("FAIL np2_sel6_valid: got %b want 0", bus_b.Y_VALID); end
        bus_b.SEL = 3'd4;
        #1;
        n_cmp++; if (bus_b.IN_READY !== 5'h10) begin n_bad++; $display("FAIL np2_sel4_inready: got %h want 10", bus_b.IN_READY); end
        tick();
        n_cmp++; if (bus_b.Y_VALID !== 1'b1 || bus_b.Y_SRC !== 3'd4 || bus_b.Y !== 8'hA4) begin
            n_bad++; $display("FAIL np2_sel4_word: got v=%b src=%0d y=%h want v=1 src=4 y=a4", bus_b.Y_VALID, bus_b.Y_SRC, bus_b.Y);
        end
        bus_b.MODE = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            x = k % 5;
            sbq.push_back('{d: 32'hA0 + 32'(x), src: 3'(x)});
            n_cmp++; if (bus_b.IN_READY !== 5'(1 << x)) begin n_bad++; $display("FAIL np2_rr_inready[%0d]: got %h want %h", k, bus_b.IN_READY, 5'(1 << x)); end
            tick();
            e = sbq.pop_front();
            n_cmp++; if (bus_b.Y_VALID !== 1'b1 || bus_b.Y_SRC !== e.src || bus_b.Y !== e.d[7:0]) begin
                n_bad++; $display("FAIL np2_rr_word[%0d]: got v=%b src=%0d y=%h want v=1 src=%0d y=%h",
                                  k, bus_b.Y_VALID, bus_b.Y_SRC, bus_b.Y, e.src, e.d[7:0]);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        bus_a.MODE = 1'b0; bus_a.SEL = '0; bus_a.IN_VALID = '0; bus_a.Y_READY = 1'b0; bus_a.IN_DATA = '0;
        bus_b.MODE = 1'b0; bus_b.SEL = '0; bus_b.IN_VALID = '0; bus_b.Y_READY = 1'b0; bus_b.IN_DATA = '0;
        load_data();
        test_reset();
        test_direct();
        test_round_robin();
        test_sparse_wrap();
        test_back_pressure();
        test_mode_switch();
        test_non_pow2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_nx1.md
# mux_rr_nx1

Parametrised, registered N-to-1 word selector with valid/ready handshaking. It supersedes the fixed 32-bit 8:1 combinational muxes wherever several producers share one consumer. Two selection modes are supported: direct select, and fair round-robin arbitration across requesting inputs. The output is held in a single register stage, so it can be placed on timing-critical paths between datapath stages.

## Interface
Parameters:
- WIDTH, 32, data width per input in bits (≥1)
- N, 8, number of inputs (2..16; need not be a power of two)
- SEL_W, 3, width of select/source fields; must equal ceil(log2(N))

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RST_N  in  1  reset, synchronous and active-low
- MODE  in  1  0 = direct select via SEL; 1 = round-robin among IN_VALID
- SEL  in  SEL_W  input index used when MODE=0
- IN_DATA  in  N*WIDTH  flattened inputs; input i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH]
- IN_VALID  in  N  per-input request
- IN_READY  out  N  per-input accept, one-hot or zero
- Y  out  WIDTH  registered output data
- Y_VALID  out  1  Y holds a word
- Y_READY  in  1  consumer accepts Y this cycle
- Y_SRC  out  SEL_W  index of the input that supplied Y

## Operation
- load = !Y_VALID | Y_READY. This is the output slot being free or draining this cycle.
- Grant, MODE=0:
  - grant = SEL when SEL < N and IN_VALID[SEL]; otherwise no grant.
  - SEL ≥ N never grants.
- Grant, MODE=1:
  - grant = the first i with IN_VALID[i], scanning from ptr upward and wrapping from N-1 to 0.
  - No grant if IN_VALID == 0.
- IN_READY[i] = load & grant_valid & (grant == i). This is combinational and depends on Y_READY.
- A transfer occurs when some IN_READY[i] & IN_VALID[i] is high. At the next edge:
  - Y ← slice i
  - Y_SRC ← i
  - Y_VALID ← 1
  - if MODE=1: ptr ← (i == N-1) ? 0 : i+1
- If load is high but there is no grant: Y_VALID ← 0. Y and Y_SRC keep their old values.
- If load is low: Y, Y_SRC and Y_VALID hold.
- Pointer behaviour across modes:
  - ptr is unchanged by MODE=0 transfers.
  - A MODE change takes effect on the next grant decision.
  - ptr is retained across a mode change.
- Producers must not make IN_VALID depend on IN_READY. IN_VALID, once asserted, must stay high until it is accepted.

## Timing
- Reset (RST_N low at an edge): Y=0, Y_SRC=0, Y_VALID=0, ptr=0. IN_READY is 0 during the reset cycle.
- Reset mid-operation discards the word held in Y. The consumer must not expect it.
- Latency: input accepted in cycle t appears on Y with Y_VALID in cycle t+1.
- Throughput: one word per cycle while Y_READY is held high.
- Back-pressure: while Y_VALID & !Y_READY, Y and Y_SRC are stable and all IN_READY are 0.
- Simultaneous drain and refill: Y_READY=1 with a grant gives back-to-back words with no bubble.
- Round-robin fairness: with all N inputs continuously valid, each input is granted exactly once every N transfers.

## Structure
- Shared header constants: MUX_MODE_SEL=1'b0, MUX_MODE_RR=1'b1.
- Sub-module rr_pick (parameters N, SEL_W):
  - inputs: REQ[N-1:0], PTR[SEL_W-1:0]
  - outputs: GNT[SEL_W-1:0], GNT_VALID
  - purely combinational rotate-priority finder.
- The top level holds:
  - the mode mux between rr_pick and SEL decode
  - the output register, Y_VALID and ptr
  - the data slice mux, written as an indexed part-select over IN_DATA.

## Test plan
- Reset: drive RST_N=0 for 2 cycles with all inputs valid. Require Y=0, Y_VALID=0, IN_READY=0. After release with MODE=1, the first grant is input 0.
- Direct select: MODE=0, SEL=5, IN_DATA slice 5 = 32'hDEADBEEF, IN_VALID=8'hFF, Y_READY=1. Require IN_READY=8'h20, and the next cycle Y=32'hDEADBEEF, Y_SRC=5. Then SEL=5 with IN_VALID[5]=0: require IN_READY=0 and Y_VALID drops.
- Round-robin: MODE=1, IN_VALID=8'hFF, Y_READY=1 for 16 cycles. Require Y_SRC sequence 0,1,…,7,0,…,7 with no bubbles.
- Sparse requests and wrap: MODE=1, IN_VALID=8'b1000_0010, ptr=2. Require grants 7, 1, 7, 1.
- Back-pressure: hold Y_READY=0 for 3 cycles with Y_VALID=1. Require Y and Y_SRC stable, IN_READY=0, ptr unchanged. Release: the next grant continues from ptr.
- Non-power-of-two: N=5, SEL_W=3, MODE=0, SEL=6 gives no grant. MODE=1 with all 5 inputs valid gives Y_SRC sequence 0..4,0.
